// File: rtl/stream_arbiter.sv
// Round-robin arbiter merging N_REQ valid/ready source streams into one
// registered output stream. A grant lasts up to MAX_BURST beats, or ends
// early when the granted requester drops valid. Each re-arbitration
// costs one IDLE cycle.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no grant; pick the next requester round-robin after 'last'
// GRANT | requester g owns the output stage; cnt counts its beats
module stream_arbiter #(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic [N_REQ-1:0]        valid_i,
    input  logic [N_REQ*DATA_W-1:0] data_i,
    output logic [N_REQ-1:0]        ready_o,
    output logic                    valid_o,
    output logic [DATA_W-1:0]       data_o,
    input  logic                    ready_i,
    output logic [N_REQ-1:0]        grant_o
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);
    // Reset pointer to the last requester so requester 0 wins first.
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic [IDX_W-1:0]   g;
    logic [IDX_W-1:0]   g_nx;
    logic [IDX_W-1:0]   last;
    logic [IDX_W-1:0]   last_nx;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nx;
    logic [IDX_W-1:0]   sel_idx;
    logic [IDX_W-1:0]   rr_idx;
    logic               sel_found;
    logic               en;
    logic               xfer;
    logic [DATA_W-1:0]  g_data;

    // Output stage can take a new beat when empty or being drained.
    assign en     = ~valid_o | ready_i;
    assign g_data = data_i[g*DATA_W +: DATA_W];

    // Round-robin search: first valid requester after 'last', wrapping.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        rr_idx    = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            rr_idx = IDX_W'((int'(last) + i) % N_REQ);
            if (!sel_found && valid_i[rr_idx]) begin
                sel_found = 1'b1;
                sel_idx   = rr_idx;
            end
        end
    end

    // Next-state, grant bookkeeping and per-requester handshake outputs.
    always_comb begin
        state_nx = state;
        g_nx     = g;
        cnt_nx   = cnt;
        last_nx  = last;
        ready_o  = '0;
        grant_o  = '0;
        xfer     = 1'b0;
        unique case (state)
            IDLE: begin
                if (sel_found) begin
                    state_nx = GRANT;
                    g_nx     = sel_idx;
                    cnt_nx   = '0;
                end
            end
            GRANT: begin
                grant_o = N_REQ'(1) << g;
                ready_o = en ? grant_o : '0;
                xfer    = valid_i[g] & en;
                // A requester that drops valid gives up the grant even while
                // the output is stalled; a full burst also ends it.
                if (!valid_i[g] || (xfer && (cnt == CNT_LAST))) begin
                    state_nx = IDLE;
                    last_nx  = g;
                    cnt_nx   = '0;
                end else if (xfer) begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Arbitration state register.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state <= IDLE;
            g     <= '0;
            cnt   <= '0;
            last  <= IDX_LAST;
        end else begin
            state <= state_nx;
            g     <= g_nx;
            cnt   <= cnt_nx;
            last  <= last_nx;
        end
    end

    // Registered output beat; data holds when no transfer happens.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            valid_o <= 1'b0;
            data_o  <= '0;
        end else if (en) begin
            valid_o <= xfer;
            if (xfer) begin
                data_o <= g_data;
            end
        end
    end

endmodule

// File: tb/tb_stream_arbiter.sv
// Self-checking bench for stream_arbiter: cycle model plus directed and
// randomized stimulus with per-requester ordering scoreboard.
module tb_stream_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int MB = 4;

    typedef logic [W-1:0] beat_q_t[$];

    logic           clk_i;
    logic           rstn_i;
    logic [N-1:0]   valid_i;
    logic [N*W-1:0] data_i;
    logic [N-1:0]   ready_o;
    logic           valid_o;
    logic [W-1:0]   data_o;
    logic           ready_i;
    logic [N-1:0]   grant_o;

    int n_cmp = 0;
    int n_fail = 0;

    beat_q_t        src_q [N];
    logic [W-1:0]   out_log[$];
    bit             gaps = 1'b0;
    int             ready_mode = 0;
    bit             sb_on = 1'b0;
    int             exp_seq [N];
    int             sb_count = 0;

    stream_arbiter #(.N_REQ(N), .DATA_W(W), .MAX_BURST(MB)) dut (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .valid_i (valid_i),
        .data_i  (data_i),
        .ready_o (ready_o),
        .valid_o (valid_o),
        .data_o  (data_o),
        .ready_i (ready_i),
        .grant_o (grant_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, run still active");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: grant owner (-1 = none), beats in the current
    // grant, round-robin pointer and the registered output beat.
    int           m_g = -1;
    int           m_cnt = 0;
    int           m_last = N - 1;
    logic         m_valid = 1'b0;
    logic [W-1:0] m_data = '0;

    always @(posedge clk_i or negedge rstn_i) begin : model
        bit en_m;
        bit xf;
        bit found;
        if (!rstn_i) begin
            m_g = -1; m_cnt = 0; m_last = N - 1; m_valid = 1'b0; m_data = '0;
        end else begin
            en_m = !m_valid || ready_i;
            if (m_g < 0) begin
                if (en_m) m_valid = 1'b0;
                found = 1'b0;
                for (int i = 1; i <= N; i++) begin
                    if (!found && valid_i[(m_last + i) % N]) begin
                        found = 1'b1;
                        m_g = (m_last + i) % N;
                    end
                end
                m_cnt = 0;
            end else begin
                xf = valid_i[m_g] && en_m;
                if (en_m) begin
                    m_valid = xf;
                    if (xf) m_data = data_i[m_g*W +: W];
                end
                if (xf) m_cnt++;
                if (!valid_i[m_g] || m_cnt == MB) begin
                    m_last = m_g; m_g = -1; m_cnt = 0;
                end
            end
        end
    end

    // Compare DUT against the model every cycle; log and scoreboard beats.
    always @(negedge clk_i) begin : monitor
        bit           en_c;
        logic [N-1:0] eg;
        logic [N-1:0] er;
        int           r;
        en_c = !m_valid || ready_i;
        eg = (m_g >= 0) ? (N'(1) << m_g) : '0;
        er = (m_g >= 0 && en_c) ? eg : '0;
        check("grant_o", grant_o, eg);
        check("ready_o", ready_o, er);
        check("valid_o", valid_o, m_valid);
        check("data_o", data_o, m_data);
        if (rstn_i && valid_o && ready_i) begin
            out_log.push_back(data_o);
            if (sb_on) begin
                r = int'(data_o[7:6]);
                check("sb_order", data_o[5:0], exp_seq[r] % 64);
                exp_seq[r]++;
                sb_count++;
            end
        end
    end

    // Source model: each requester offers the head of its queue.
    initial begin : driver
        logic [N-1:0] acc;
        valid_i = '0;
        data_i  = '0;
        ready_i = 1'b1;
        forever begin
            @(negedge clk_i);
            acc = valid_i & ready_o;
            @(posedge clk_i);
            #1;
            for (int k = 0; k < N; k++) begin
                if (rstn_i && acc[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
                valid_i[k] = (src_q[k].size() > 0) && (!gaps || $urandom_range(3) != 0);
                data_i[k*W +: W] = (src_q[k].size() > 0) ? src_q[k][0] : W'($urandom);
            end
            case (ready_mode)
                0:       ready_i = 1'b1;
                2:       ready_i = 1'b0;
                default: ready_i = ($urandom_range(3) != 0);
            endcase
        end
    end

    task automatic do_reset();
        @(negedge clk_i);
        #2;
        rstn_i = 1'b0;
        for (int k = 0; k < N; k++) src_q[k].delete();
        repeat (2) @(negedge clk_i);
        #1;
        out_log.delete();
        rstn_i = 1'b1;
    endtask

    task automatic wait_log(input int n, input int budget, input string name);
        int c = 0;
        while (out_log.size() < n && c < budget) begin
            @(negedge clk_i);
            #1;
            c++;
        end
        check(name, (out_log.size() >= n), 1);
    endtask

    initial begin : main
        logic         vrec[$];
        logic [W-1:0] drec[$];
        logic [N-1:0] glist[$];
        logic         ev [7];
        logic [W-1:0] ed [7];
        logic [N-1:0] ge [4];
        int           first;
        int           r;
        int           s;
        bit           found;
        int           c;
        int           left;

        // Power-up reset: outputs must be zero while reset is held.
        rstn_i = 1'b1;
        #2;
        rstn_i = 1'b0;
        #1;
        check("a_reset_valid", valid_o, 0);
        check("a_reset_data", data_o, 0);
        check("a_reset_ready", ready_o, 0);
        check("a_reset_grant", grant_o, 0);

        // Single requester 0 offering 1..6: 1,2,3,4, bubble, 5,6.
        do_reset();
        for (int j = 1; j <= 6; j++) src_q[0].push_back(W'(j));
        for (int i = 0; i < 16; i++) begin
            @(negedge clk_i);
            #1;
            vrec.push_back(valid_o);
            drec.push_back(data_o);
            if (grant_o != '0) check("b_grant", grant_o, 4'b0001);
        end
        ev = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        ed = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd0, 8'd5, 8'd6};
        first = -1;
        for (int i = 0; i < vrec.size(); i++) if (first < 0 && vrec[i]) first = i;
        check("b_started", (first >= 0 && first + 7 <= vrec.size()), 1);
        if (first >= 0 && first + 7 <= vrec.size()) begin
            for (int i = 0; i < 7; i++) begin
                check("b_valid_pattern", vrec[first+i], ev[i]);
                if (ev[i]) check("b_data", drec[first+i], ed[i]);
            end
        end

        // Round robin across all four requesters, 5 beats each.
        do_reset();
        for (int k = 0; k < N; k++)
            for (int j = 0; j < 5; j++) src_q[k].push_back(W'((k << 6) | j));
        wait_log(20, 300, "c_done");
        for (int i = 0; i < 20 && i < out_log.size(); i++) begin
            if (i < 16) begin
                r = i / 4; s = i % 4;
            end else begin
                r = i - 16; s = 4;
            end
            check("c_beat", out_log[i], (r << 6) | s);
        end

        // Backpressure for 3 cycles in the middle of a burst.
        do_reset();
        for (int j = 0; j < 8; j++) src_q[0].push_back(W'(8'h10 + j));
        wait_log(2, 50, "d_start");
        ready_mode = 2;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            #1;
            check("d_stall_valid", valid_o, 1);
            check("d_stall_data", data_o, 8'h12);
            check("d_stall_ready", ready_o, 0);
            check("d_stall_grant", grant_o, 4'b0001);
        end
        ready_mode = 0;
        wait_log(8, 60, "d_done");
        for (int i = 0; i < 8 && i < out_log.size(); i++)
            check("d_beat", out_log[i], 8'h10 + i);

        // Early release: requester 2 stops after 2 beats, requester 3 waits.
        do_reset();
        src_q[2].push_back(8'h80);
        src_q[2].push_back(8'h81);
        for (int j = 0; j < 3; j++) src_q[3].push_back(W'(8'hC0 + j));
        for (int i = 0; i < 30; i++) begin
            @(negedge clk_i);
            #1;
            if (glist.size() == 0 || glist[glist.size()-1] != grant_o) glist.push_back(grant_o);
        end
        ge = '{4'b0000, 4'b0100, 4'b0000, 4'b1000};
        check("e_grant_steps", (glist.size() >= 4), 1);
        for (int i = 0; i < 4 && i < glist.size(); i++) check("e_grant_seq", glist[i], ge[i]);
        wait_log(5, 50, "e_done");
        ed[0] = 8'h80; ed[1] = 8'h81; ed[2] = 8'hC0; ed[3] = 8'hC1; ed[4] = 8'hC2;
        for (int i = 0; i < 5 && i < out_log.size(); i++) check("e_beat", out_log[i], ed[i]);

        // Reset while requester 1 beat 3 sits in the output register.
        do_reset();
        for (int j = 0; j < 6; j++) src_q[1].push_back(W'(8'h40 + j));
        found = 1'b0;
        c = 0;
        while (!found && c < 60) begin
            @(negedge clk_i);
            if (valid_o && data_o == 8'h42) found = 1'b1;
            c++;
        end
        check("f_beat3_seen", found, 1);
        #2;
        rstn_i = 1'b0;
        #1;
        check("f_async_valid", valid_o, 0);
        check("f_async_data", data_o, 0);
        check("f_async_ready", ready_o, 0);
        check("f_async_grant", grant_o, 0);
        src_q[0].push_back(8'h01);
        src_q[0].push_back(8'h02);
        repeat (2) @(negedge clk_i);
        #1;
        out_log.delete();
        rstn_i = 1'b1;
        found = 1'b0;
        c = 0;
        while (!found && c < 20) begin
            @(negedge clk_i);
            #1;
            if (grant_o != '0) found = 1'b1;
            c++;
        end
        check("f_regrant_seen", found, 1);
        check("f_first_grant", grant_o, 4'b0001);
        wait_log(1, 20, "f_first_beat_seen");
        if (out_log.size() > 0) check("f_first_beat", out_log[0], 8'h01);
        repeat (30) @(negedge clk_i);

        // Randomized traffic: valid gaps and random fifo backpressure.
        do_reset();
        for (int k = 0; k < N; k++) exp_seq[k] = 0;
        sb_count = 0;
        sb_on = 1'b1;
        gaps = 1'b1;
        ready_mode = 1;
        for (int k = 0; k < N; k++)
            for (int j = 0; j < 40; j++) src_q[k].push_back(W'((k << 6) | j));
        c = 0;
        while (sb_count < 4 * 40 && c < 4000) begin
            @(negedge clk_i);
            #1;
            c++;
        end
        ready_mode = 0;
        gaps = 1'b0;
        repeat (20) @(negedge clk_i);
        check("g_beat_count", sb_count, 4 * 40);
        left = 0;
        for (int k = 0; k < N; k++) left += src_q[k].size();
        check("g_sources_drained", left, 0);
        sb_on = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/stream_arbiter.md
STREAM_ARBITER -- requirements
Module: stream_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesting valid/ready source channels (2..8).
REQ-002 Parameter DATA_W, default 8, data width per beat.
REQ-003 Parameter MAX_BURST, default 4, maximum consecutive beats per grant (1..16).
REQ-004 clk_i  input  1  single clock; all state on rising edge.
REQ-005 rstn_i  input  1  reset, asynchronous and active-low.
REQ-006 valid_i  input  N_REQ  per-requester beat valid.
REQ-007 data_i  input  N_REQ*DATA_W  per-requester data; requester k occupies bits [k*DATA_W +: DATA_W].
REQ-008 ready_o  output  N_REQ  per-requester ready.
REQ-009 valid_o  output  1  registered beat valid toward fifo input.
REQ-010 data_o  output  DATA_W  registered beat data toward fifo input.
REQ-011 ready_i  input  1  fifo ready.
REQ-012 grant_o  output  N_REQ  one-hot current grant; all zero when no grant.

Function
REQ-013 Output stage enable en = !valid_o | ready_i; valid_o/data_o update only when en=1.
REQ-014 States: IDLE, GRANT; state, grant index g, beat counter cnt and round-robin pointer last are registered.
REQ-015 IDLE: if any valid_i set, select the first set requester searching last+1, last+2, ... modulo N_REQ; go to GRANT with g = selection and cnt = 0; otherwise stay in IDLE.
REQ-016 IDLE: ready_o all zero, grant_o all zero; no beat accepted.
REQ-017 GRANT: ready_o[g] = en, all other ready_o bits zero; grant_o = one-hot(g).
REQ-018 Transfer occurs when valid_i[g] & ready_o[g]; valid_o <= 1 and data_o <= data_i[g] on the next edge (latency 1 cycle).
REQ-019 When en=1 and no transfer occurs, valid_o <= 0 and data_o holds its value.
REQ-020 Each transfer increments cnt; a transfer with cnt = MAX_BURST-1 ends the grant.
REQ-021 GRANT with valid_i[g]=0 ends the grant, whatever en is.
REQ-022 Ending a grant: state <= IDLE, last <= g, cnt <= 0; re-arbitration takes one IDLE cycle (one bubble).
REQ-023 ready_i=0 with valid_o=1: valid_o, data_o, cnt and g hold; ready_o all zero.
REQ-024 A requester dropping valid_i without a transfer loses no data and is not counted.
REQ-025 No beat is duplicated or dropped; per-requester order is preserved at data_o.
REQ-026 Requester valid_i/data_i changes outside GRANT for that requester have no effect.

Reset
REQ-027 rstn_i=0 immediately forces valid_o=0, data_o=0, ready_o=0, grant_o=0, state=IDLE, cnt=0, last=N_REQ-1, so requester 0 has first priority.
REQ-028 Reset mid-burst discards the in-flight output beat; after release, arbitration restarts from requester 0.

Verification (N_REQ=4, DATA_W=8, MAX_BURST=4)
REQ-029 Reset: assert rstn_i between edges -> all outputs 0 without waiting for a clock edge; release -> first grant goes to lowest-index active requester.
REQ-030 Single requester: requester 0 offers 1..6, ready_i=1 -> data_o sequence 1,2,3,4, one idle cycle with valid_o=0, then 5,6; grant_o=0001 throughout each grant.
REQ-031 Round-robin: all four requesters valid continuously, ready_i=1 -> grants 0,1,2,3,0, each 4 beats, in order, with one bubble between grants.
REQ-032 Backpressure: ready_i=0 for 3 cycles mid-burst -> valid_o=1 and data_o stable, ready_o=0000, cnt unchanged; burst resumes with no loss.
REQ-033 Early release: requester 2 drops valid_i after 2 beats while requester 3 is waiting -> grant_o goes 0100 -> 0000 -> 1000; requester 3 data follows.
REQ-034 Reset mid-burst: assert rstn_i during requester 1 beat 3 -> valid_o=0 at once; after release, requester 0 is served first.
